// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared definitions for the tic-tac-toe game controller.
//   - state and winner encodings seen on the controller outputs
//   - board size and full-board constant
//   - the eight line masks in DetectWinner's win_line bit order
//     (bit 8 of a board = top-left square, bit 0 = bottom-right)
//   - one-hot helper used by the move checker
package tictactoe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_A    = 2'b01,
    W_B    = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

  localparam int NUM_SQUARES = 9;
  localparam logic [NUM_SQUARES-1:0] FULL_BOARD = 9'h1FF;

  // Index i is the square set reported on win_line[i]:
  // rows top/middle/bottom, columns left/middle/right, main diag, anti diag.
  localparam logic [NUM_SQUARES-1:0] LINE_MASK [8] = '{
    9'h1C0, 9'h038, 9'h007,
    9'h124, 9'h092, 9'h049,
    9'h111, 9'h054
  };

  // True when exactly one bit of v is set.
  function automatic logic is_onehot9(input logic [NUM_SQUARES-1:0] v);
    return (v != 9'h000) && ((v & (v - 9'h001)) == 9'h000);
  endfunction

endpackage

// File: rtl/ttt_move_check.sv
// ttt_move_check: combinational legality check for a requested move.
// Ports:
//   move_pos  in  9  requested square, one-hot
//   occupied  in  9  squares already taken by either player
//   legal     out 1  exactly one square requested and it is free
//   is_onehot out 1  exactly one square requested
module ttt_move_check
  import tictactoe_pkg::*;
(
  input  logic [NUM_SQUARES-1:0] move_pos,
  input  logic [NUM_SQUARES-1:0] occupied,
  output logic                   legal,
  output logic                   is_onehot
);

  assign is_onehot = is_onehot9(move_pos);
  assign legal     = is_onehot && ((move_pos & occupied) == 9'h000);

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game controller around an external DetectWinner.
// Holds both players' boards, accepts moves over valid/ready, evaluates the
// board one cycle after each accepted move and declares win or draw.
// Build option: define TTT_UNDO_EN to add the undo input and a one-level
// move history (last square, last mover, valid flag).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                clear board and begin a game (any state, top priority)
//   move_valid/move_pos  move request, one-hot square
//   move_ready           high only in PLAY
//   move_err             1-cycle pulse after a rejected move
//   a_pos, b_pos         player boards, to DetectWinner ain/bin
//   win_line             from DetectWinner, bits 7:0 used
//   turn                 player to move (0=A, 1=B)
//   state                IDLE=0, PLAY=1, EVAL=2, DONE=3
//   winner               00 none, 01 A, 10 B, 11 draw
//   win_mask             win_line[7:0] latched at game end
//   turn_timeout         1-cycle pulse when a stalled turn is forfeited
//   undo                 (TTT_UNDO_EN only) take back the last move
module ttt_game_ctrl
  import tictactoe_pkg::*;
#(
  parameter int FIRST_PLAYER   = 0,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   move_valid,
  input  logic [NUM_SQUARES-1:0] move_pos,
  output logic                   move_ready,
  output logic                   move_err,
  output logic [NUM_SQUARES-1:0] a_pos,
  output logic [NUM_SQUARES-1:0] b_pos,
  input  logic [NUM_SQUARES-1:0] win_line,
  output logic                   turn,
  output logic [1:0]             state,
  output logic [1:0]             winner,
  output logic [7:0]             win_mask,
  output logic                   turn_timeout
`ifdef TTT_UNDO_EN
  ,
  input  logic                   undo
`endif
);

  localparam bit   TIMER_EN   = (TIMEOUT_CYCLES > 0);
  localparam int   TW         = TIMER_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int   LAST_I     = TIMER_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LAST_I);
  localparam logic FIRST_TURN = (FIRST_PLAYER != 0) ? 1'b1 : 1'b0;

  state_e                   state_r, state_s;
  winner_e                  winner_r, winner_s;
  logic [NUM_SQUARES-1:0]   a_r, a_s, b_r, b_s;
  logic                     turn_r, turn_s;
  logic [7:0]               mask_r, mask_s;
  logic                     err_r, err_s;
  logic                     to_r, to_s;
  logic [TW-1:0]            timer_r, timer_s, timer_inc_s;
  logic                     timeout_hit_s;
  logic                     legal_s, onehot_s;
  logic                     unused_wl8_s;
`ifdef TTT_UNDO_EN
  logic [NUM_SQUARES-1:0]   hist_pos_r, hist_pos_s;
  logic                     hist_player_r, hist_player_s;
  logic                     hist_valid_r, hist_valid_s;
`endif

  // DetectWinner only reports eight lines; its bit 8 carries nothing.
  assign unused_wl8_s = win_line[8];

  ttt_move_check u_move_check (
    .move_pos  (move_pos),
    .occupied  (a_r | b_r),
    .legal     (legal_s),
    .is_onehot (onehot_s)
  );

  assign timer_inc_s   = TIMER_EN ? (timer_r + TW'(1)) : {TW{1'b0}};
  assign timeout_hit_s = TIMER_EN && (timer_r == TIMER_LAST);

  // Next-state and next-output logic for the game sequencer.
  // Within PLAY the order is: legal move, rejected move, undo, idle.
  // A rejected move landing on the timeout edge is absorbed by the timeout
  // (the turn passes) so move_err and turn_timeout can never pulse together.
  always_comb begin
    state_s  = state_r;
    winner_s = winner_r;
    a_s      = a_r;
    b_s      = b_r;
    turn_s   = turn_r;
    mask_s   = mask_r;
    err_s    = 1'b0;
    to_s     = 1'b0;
    timer_s  = timer_r;
`ifdef TTT_UNDO_EN
    hist_pos_s    = hist_pos_r;
    hist_player_s = hist_player_r;
    hist_valid_s  = hist_valid_r;
`endif
    if (start) begin
      state_s  = PLAY;
      winner_s = W_NONE;
      a_s      = 9'h000;
      b_s      = 9'h000;
      turn_s   = FIRST_TURN;
      mask_s   = 8'h00;
      timer_s  = {TW{1'b0}};
`ifdef TTT_UNDO_EN
      hist_pos_s    = 9'h000;
      hist_player_s = 1'b0;
      hist_valid_s  = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        PLAY: begin
          if (move_valid && legal_s) begin
            if (turn_r) begin
              b_s = b_r | move_pos;
            end else begin
              a_s = a_r | move_pos;
            end
            timer_s = {TW{1'b0}};
            state_s = EVAL;
`ifdef TTT_UNDO_EN
            hist_pos_s    = move_pos;
            hist_player_s = turn_r;
            hist_valid_s  = 1'b1;
`endif
          end else if (move_valid) begin
            if (timeout_hit_s) begin
              turn_s  = ~turn_r;
              timer_s = {TW{1'b0}};
              to_s    = 1'b1;
            end else begin
              err_s   = 1'b1;
              timer_s = timer_inc_s;
            end
`ifdef TTT_UNDO_EN
          end else if (undo && hist_valid_r) begin
            if (hist_player_r) begin
              b_s = b_r & ~hist_pos_r;
            end else begin
              a_s = a_r & ~hist_pos_r;
            end
            turn_s       = hist_player_r;
            hist_valid_s = 1'b0;
            timer_s      = {TW{1'b0}};
`endif
          end else if (timeout_hit_s) begin
            turn_s  = ~turn_r;
            timer_s = {TW{1'b0}};
            to_s    = 1'b1;
          end else begin
            timer_s = timer_inc_s;
          end
        end
        EVAL: begin
          // win_line already reflects the board updated on the previous edge.
          if (win_line[7:0] != 8'h00) begin
            winner_s = turn_r ? W_B : W_A;
            mask_s   = win_line[7:0];
            state_s  = DONE;
          end else if ((a_r | b_r) == FULL_BOARD) begin
            winner_s = W_DRAW;
            state_s  = DONE;
          end else begin
            turn_s  = ~turn_r;
            state_s = PLAY;
          end
        end
        DONE: state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      winner_r <= W_NONE;
      a_r      <= 9'h000;
      b_r      <= 9'h000;
      turn_r   <= FIRST_TURN;
      mask_r   <= 8'h00;
      err_r    <= 1'b0;
      to_r     <= 1'b0;
      timer_r  <= {TW{1'b0}};
    end else begin
      state_r  <= state_s;
      winner_r <= winner_s;
      a_r      <= a_s;
      b_r      <= b_s;
      turn_r   <= turn_s;
      mask_r   <= mask_s;
      err_r    <= err_s;
      to_r     <= to_s;
      timer_r  <= timer_s;
    end
  end

`ifdef TTT_UNDO_EN
  // One-level move history for undo.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_pos_r    <= 9'h000;
      hist_player_r <= 1'b0;
      hist_valid_r  <= 1'b0;
    end else begin
      hist_pos_r    <= hist_pos_s;
      hist_player_r <= hist_player_s;
      hist_valid_r  <= hist_valid_s;
    end
  end
`endif

  assign move_ready   = (state_r == PLAY);
  assign move_err     = err_r;
  assign turn_timeout = to_r;
  assign a_pos        = a_r;
  assign b_pos        = b_r;
  assign turn         = turn_r;
  assign state        = state_r;
  assign winner       = winner_r;
  assign win_mask     = mask_r;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: scoreboard bench for ttt_game_ctrl (FIRST_PLAYER=0,
// TIMEOUT_CYCLES=4). A stand-in for DetectWinner drives win_line from the
// DUT boards. The driver pushes the expected post-edge outputs of a
// square-ownership reference model; a monitor pops and compares them.
// Undo stimulus is exercised when TTT_UNDO_EN is defined.
module tb_ttt_game_ctrl;
  import tictactoe_pkg::*;

  localparam int FP = 0;
  localparam int TO = 4;
`ifdef TTT_UNDO_EN
  localparam bit UNDO_ON = 1'b1;
`else
  localparam bit UNDO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, move_valid = 1'b0, undo = 1'b0;
  logic [8:0] move_pos = 9'h000;
  logic       move_ready, move_err, turn, turn_timeout;
  logic [8:0] a_pos, b_pos, win_line;
  logic [1:0] state, winner;
  logic [7:0] win_mask;
  logic       wl_junk = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  ttt_game_ctrl #(.FIRST_PLAYER(FP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .move_valid(move_valid), .move_pos(move_pos),
    .move_ready(move_ready), .move_err(move_err),
    .a_pos(a_pos), .b_pos(b_pos), .win_line(win_line),
    .turn(turn), .state(state), .winner(winner),
    .win_mask(win_mask), .turn_timeout(turn_timeout)
`ifdef TTT_UNDO_EN
    , .undo(undo)
`endif
  );

  always #5 clk = ~clk;

  // DetectWinner stand-in: a line is set when either player owns all of it.
  always_comb begin
    win_line = {wl_junk, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (((a_pos & LINE_MASK[i]) == LINE_MASK[i]) ||
          ((b_pos & LINE_MASK[i]) == LINE_MASK[i]))
        win_line[i] = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  int lines [8][3] = '{'{8,7,6}, '{5,4,3}, '{2,1,0}, '{8,5,2},
                       '{7,4,1}, '{6,3,0}, '{8,4,0}, '{6,4,2}};
  int m_owner [9];       // 0 empty, 1 A, 2 B
  int m_state, m_turn, m_winner, m_mask, m_timer;
  bit m_err, m_to;
  int h_sq, h_pl;
  bit h_valid;

  typedef struct {
    logic [1:0] st; logic tn; logic [8:0] a; logic [8:0] b;
    logic [1:0] w; logic [7:0] m; logic rdy; logic err; logic to;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [8:0] board_of(input int who);
    logic [8:0] v = 9'h000;
    for (int i = 0; i < 9; i++) if (m_owner[i] == who) v[i] = 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) m_owner[i] = 0;
    m_state = 0; m_turn = FP; m_winner = 0; m_mask = 0; m_timer = 0;
    m_err = 1'b0; m_to = 1'b0; h_valid = 1'b0; h_sq = 0; h_pl = 0;
  endfunction

  function automatic void model_timeout();
    m_turn = 1 - m_turn; m_timer = 0; m_to = 1'b1;
  endfunction

  function automatic void model_step(input bit s, input bit mv, input logic [8:0] p, input bit u);
    int sq = 0;
    int msk = 0;
    bit full = 1'b1;
    for (int i = 0; i < 9; i++) if (p[i]) sq = i;
    m_err = 1'b0; m_to = 1'b0;
    if (s) begin
      model_reset();
      m_state = 1;
    end else if (m_state == 1) begin
      if (mv) begin
        if ($countones(p) == 1 && m_owner[sq] == 0) begin
          m_owner[sq] = m_turn + 1;
          h_sq = sq; h_pl = m_turn; h_valid = 1'b1;
          m_timer = 0; m_state = 2;
        end else if (m_timer == TO - 1) model_timeout();
        else begin m_err = 1'b1; m_timer++; end
      end else if (UNDO_ON && u && h_valid) begin
        m_owner[h_sq] = 0; m_turn = h_pl; h_valid = 1'b0; m_timer = 0;
      end else if (m_timer == TO - 1) model_timeout();
      else m_timer++;
    end else if (m_state == 2) begin
      for (int l = 0; l < 8; l++)
        if (m_owner[lines[l][0]] != 0 && m_owner[lines[l][0]] == m_owner[lines[l][1]] &&
            m_owner[lines[l][1]] == m_owner[lines[l][2]]) msk |= (1 << l);
      for (int i = 0; i < 9; i++) if (m_owner[i] == 0) full = 1'b0;
      if (msk != 0) begin m_winner = m_turn + 1; m_mask = msk; m_state = 3; end
      else if (full) begin m_winner = 3; m_state = 3; end
      else begin m_turn = 1 - m_turn; m_state = 1; end
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.st = 2'(m_state); e.tn = m_turn[0]; e.a = board_of(1); e.b = board_of(2);
    e.w = 2'(m_winner); e.m = 8'(m_mask); e.rdy = (m_state == 1);
    e.err = m_err; e.to = m_to;
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
  endtask

  task automatic cmp(input exp_t e);
    chk("state", 32'(state), 32'(e.st));
    chk("turn", 32'(turn), 32'(e.tn));
    chk("a_pos", 32'(a_pos), 32'(e.a));
    chk("b_pos", 32'(b_pos), 32'(e.b));
    chk("winner", 32'(winner), 32'(e.w));
    chk("win_mask", 32'(win_mask), 32'(e.m));
    chk("move_ready", 32'(move_ready), 32'(e.rdy));
    chk("move_err", 32'(move_err), 32'(e.err));
    chk("turn_timeout", 32'(turn_timeout), 32'(e.to));
    chk("err_to_exclusive", 32'(move_err & turn_timeout), 32'd0);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) cmp(exp_q.pop_front());
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit mv, input logic [8:0] p, input bit u);
    @(negedge clk); #1;
    start = s; move_valid = mv; move_pos = p; undo = u;
    wl_junk = 1'($urandom_range(1));
    model_step(s, mv, p, u);
    exp_q.push_back(snap());
  endtask

  task automatic play(input logic [8:0] p);
    step(1'b0, 1'b1, p, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic reset_now();
    @(negedge clk); #1;
    start = 1'b0; move_valid = 1'b0; move_pos = 9'h000; undo = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    cmp(snap());
    exp_q.push_back(snap());
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] p;
    model_reset();
    #1;
    cmp(snap());
    @(negedge clk); #1;
    reset_n = 1'b1;

    // A wins on the top row.
    step(1'b1, 1'b0, 9'h000, 1'b0);
    play(9'h100); play(9'h008); play(9'h080); play(9'h010); play(9'h040);
    settle();
    chk("awin_winner", 32'(winner), 32'h1);
    chk("awin_mask", 32'(win_mask), 32'h01);
    chk("awin_ready", 32'(move_ready), 32'h0);
    step(1'b0, 1'b1, 9'h001, 1'b0);   // ignored in DONE

    // Rejected moves: two-hot, then an occupied square.
    step(1'b1, 1'b0, 9'h000, 1'b0);
    step(1'b0, 1'b1, 9'h003, 1'b0);
    play(9'h100);
    step(1'b0, 1'b1, 9'h100, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b0);

    // Full-board draw ending with A on the bottom-right square.
    step(1'b1, 1'b0, 9'h000, 1'b0);
    play(9'h100); play(9'h010); play(9'h040); play(9'h080); play(9'h020);
    play(9'h004); play(9'h002); play(9'h008); play(9'h001);
    settle();
    chk("draw_winner", 32'(winner), 32'h3);
    chk("draw_board", 32'(a_pos | b_pos), 32'h1FF);

    // Last move fills the board and completes two lines: mover wins.
    step(1'b1, 1'b0, 9'h000, 1'b0);
    play(9'h100); play(9'h080); play(9'h040); play(9'h004); play(9'h010);
    play(9'h020); play(9'h008); play(9'h002); play(9'h001);
    settle();
    chk("fullwin_winner", 32'(winner), 32'h1);
    chk("fullwin_mask", 32'(win_mask), 32'h60);

    // Timeout after four idle PLAY cycles, then a legal move on the 4th.
    step(1'b1, 1'b0, 9'h000, 1'b0);
    repeat (4) step(1'b0, 1'b0, 9'h000, 1'b0);
    settle();
    chk("timeout_turn", 32'(turn), 32'h1);
    repeat (3) step(1'b0, 1'b0, 9'h000, 1'b0);
    step(1'b0, 1'b1, 9'h010, 1'b0);
    settle();
    chk("timeout_move_state", 32'(state), 32'h2);

    // Reset while in EVAL, then start from DONE after a fresh win.
    step(1'b1, 1'b0, 9'h000, 1'b0);
    step(1'b0, 1'b1, 9'h100, 1'b0);
    reset_now();
    step(1'b1, 1'b0, 9'h000, 1'b0);
    play(9'h100); play(9'h008); play(9'h080); play(9'h010); play(9'h040);
    step(1'b1, 1'b0, 9'h000, 1'b0);
    settle();
    chk("restart_board", 32'(a_pos | b_pos), 32'h0);

`ifdef TTT_UNDO_EN
    play(9'h010);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    settle();
    chk("undo_a", 32'(a_pos), 32'h0);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    step(1'b0, 1'b1, 9'h100, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b0);
`endif

    // Randomised play.
    for (int n = 0; n < 1200; n++) begin
      if (n % 400 == 399 && m_state == 2) reset_now();
      case ($urandom_range(3))
        0, 1:    p = 9'h001 << $urandom_range(8);
        2:       p = 9'($urandom_range(511));
        default: p = 9'h000;
      endcase
      step((m_state == 3 || m_state == 0 || $urandom_range(60) == 0),
           ($urandom_range(9) < 6), p, ($urandom_range(4) == 0));
    end

    step(1'b0, 1'b0, 9'h000, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
